ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single-port 8x256 RAM (wren/address/data in, q out, address registered inside the RAM).
- Each requester issues single read or write transfers with a req/gnt handshake, and may lock the RAM for back-to-back bursts.
- The arbiter registers all RAM-side inputs and returns read data to the issuing requester with a fixed latency and an rvalid strobe.

---
 rtl/ram_pkg.sv | 16 +
 rtl/rr_arb2.sv | 27 ++
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants for the two-requester RAM arbiter.
package ram_pkg;

  localparam int unsigned RAM_DATA_WIDTH = 8;
  localparam int unsigned RAM_ADDR_WIDTH = 8;

  // Ownership FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Requester identifiers, also carried down the read-return pipeline
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with lock ownership; purely combinational.
module rr_arb2
  import ram_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] state_i,
  output logic [1:0] gnt_o
);

  // Owner sees only its own request; otherwise the requester not granted last wins a tie
  always_comb begin
    gnt_o = 2'b00;
    case (state_i)
      ST_OWN0: gnt_o[0] = req_i[0];
      ST_OWN1: gnt_o[1] = req_i[1];
      default: begin
        if (&req_i) begin
          gnt_o = (last_i == REQ_ID1) ? 2'b01 : 2'b10;
        end else begin
          gnt_o = req_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port RAM with
// registered RAM-side signals and a fixed-latency, id-steered read return.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic [1:0]            arb_gnt;
  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;

  logic                  acc0, acc1, acc;
  logic                  acc_id, acc_we, acc_lock;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic                  ram_wren_q, ram_wren_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;

  // Read tag captured at acceptance, then two pipeline stages to match RAM latency
  logic                  tag_vld_q, tag_vld_d;
  logic                  tag_id_q, tag_id_d;
  logic                  s1_vld_q, s1_id_q;
  logic                  s2_vld_q, s2_id_q;

  rr_arb2 u_arb (
    .req_i   ({req1, req0}),
    .last_i  (last_q),
    .state_i (state_q),
    .gnt_o   (arb_gnt)
  );

  // Grants are held low while reset is asserted
  assign gnt0 = arb_gnt[0] & rst_n;
  assign gnt1 = arb_gnt[1] & rst_n;

  // Select the payload of the accepted requester
  always_comb begin
    acc       = 1'b0;
    acc_id    = REQ_ID0;
    acc_we    = we0;
    acc_lock  = lock0;
    acc_addr  = addr0;
    acc_wdata = wdata0;
    acc0      = req0 & gnt0;
    acc1      = req1 & gnt1;
    acc       = acc0 | acc1;
    if (acc1) begin
      acc_id    = REQ_ID1;
      acc_we    = we1;
      acc_lock  = lock1;
      acc_addr  = addr1;
      acc_wdata = wdata1;
    end
  end

  // Next-state: ownership, round-robin pointer, RAM-side registers and read tag
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    ram_wren_d    = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    tag_vld_d     = 1'b0;
    tag_id_d      = REQ_ID0;
    if (acc) begin
      ram_wren_d    = acc_we;
      ram_address_d = acc_addr;
      ram_data_d    = acc_wdata;
      last_d        = acc_id;
      tag_vld_d     = ~acc_we;
      tag_id_d      = acc_id;
      if (acc_lock) begin
        state_d = (acc_id == REQ_ID1) ? ST_OWN1 : ST_OWN0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State, RAM-side and read-return registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_q        <= REQ_ID1;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      tag_vld_q     <= 1'b0;
      tag_id_q      <= REQ_ID0;
      s1_vld_q      <= 1'b0;
      s1_id_q       <= REQ_ID0;
      s2_vld_q      <= 1'b0;
      s2_id_q       <= REQ_ID0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      s1_vld_q      <= tag_vld_q;
      s1_id_q       <= tag_id_q;
      s2_vld_q      <= s1_vld_q;
      s2_id_q       <= s1_id_q;
    end
  end

  assign ram_wren    = ram_wren_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;

  // Steer the returning RAM word to the requester that issued the read
  assign rvalid0 = s2_vld_q & (s2_id_q == REQ_ID0);
  assign rvalid1 = s2_vld_q & (s2_id_q == REQ_ID1);
  assign rdata0  = rvalid0 ? ram_q : '0;
  assign rdata1  = rvalid1 ? ram_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of grants, memory and returns.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, lock0 = 1'b0, we0 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0;
  logic       req1 = 1'b0, lock1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr1 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_wren;
  logic [7:0] ram_address, ram_data;
  logic [7:0] ram_q = '0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  // Single-port RAM: address registered inside, output registered
  logic [7:0] mem [256];
  logic [7:0] ram_a_q = '0;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_a_q <= ram_address;
    ram_q   <= mem[ram_a_q];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner (-1 none), last winner, memory image, expected returns
  typedef struct { int due; int id; logic [7:0] data; } ret_t;
  ret_t       rq[$];
  int         m_owner = -1;
  int         m_last  = 1;
  logic [7:0] m_mem [256];
  logic       e_wren = 1'b0;
  logic [7:0] e_addr = '0, e_data = '0;
  int         cyc = 0;
  logic [7:0] seen_rd0 = '0;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    e_wren  = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    rq.delete();
  endtask

  task automatic step(input logic r0, l0, w0, input logic [7:0] a0, d0,
                      input logic r1, l1, w1, input logic [7:0] a1, d1,
                      output int g);
    logic       xw, xl;
    logic [7:0] xa, xd;
    logic       ev0, ev1;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    g = -1;
    if (m_owner == 0)      g = r0 ? 0 : -1;
    else if (m_owner == 1) g = r1 ? 1 : -1;
    else if (r0 && r1)     g = (m_last == 0) ? 1 : 0;
    else if (r0)           g = 0;
    else if (r1)           g = 1;
    @(negedge clk);
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      xw = (g == 0) ? w0 : w1;
      xl = (g == 0) ? l0 : l1;
      xa = (g == 0) ? a0 : a1;
      xd = (g == 0) ? d0 : d1;
      e_wren = xw;
      e_addr = xa;
      e_data = xd;
      if (xw) m_mem[xa] = xd;
      else    rq.push_back('{cyc + 2, g, m_mem[xa]});
      m_last  = g;
      m_owner = xl ? g : -1;
    end else begin
      e_wren = 1'b0;
    end
    chk("ram_wren", 32'(ram_wren), 32'(e_wren));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    chk("ram_data", 32'(ram_data), 32'(e_data));
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev0 = (rq[0].id == 0);
      ev1 = (rq[0].id == 1);
      if (ev0) chk("rdata0", 32'(rdata0), 32'(rq[0].data));
      if (ev1) chk("rdata1", 32'(rdata1), 32'(rq[0].data));
      void'(rq.pop_front());
    end
    chk("rvalid0", 32'(rvalid0), 32'(ev0));
    chk("rvalid1", 32'(rvalid1), 32'(ev1));
    if (rvalid0) seen_rd0 = rdata0;
  endtask

  // Assert reset with both requests high, confirm quiescent outputs, release
  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_rvalid0_b", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1_b", 32'(rvalid1), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, g);
  endtask

  initial begin
    int         g;
    logic       p_v [2];
    logic       p_l [2];
    logic       p_w [2];
    logic [7:0] p_a [2];
    logic [7:0] p_d [2];

    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    #2;
    do_reset();

    // Write then read back from requester 0
    step(1, 0, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, g);
    step(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, g);
    idle(3);
    chk("wr_rd_0x10", 32'(seen_rd0), 32'h0000_00A5);

    // Preload and alternating contended reads
    step(1, 0, 1, 8'h01, 8'h11, 0, 0, 0, 8'h00, 8'h00, g);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h02, 8'h22, g);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, g);
    idle(3);

    // Locked burst by requester 0 while requester 1 waits
    for (int i = 0; i < 4; i++)
      step(1, (i < 3), 1, 8'(8'h20 + i), 8'(8'hC0 + i), 1, 0, 0, 8'h21, 8'h00, g);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h21, 8'h00, g);
    idle(3);

    // Owner idles while holding the lock
    step(1, 1, 1, 8'h40, 8'h77, 0, 0, 0, 8'h00, 8'h00, g);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, g);
    step(1, 0, 0, 8'h40, 8'h00, 1, 0, 0, 8'h40, 8'h00, g);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, g);
    idle(3);

    // Reset with a read in flight, then first contention after release
    step(1, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, g);
    do_reset();
    idle(3);
    step(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, g);
    idle(3);

    // Write by requester 1 immediately followed by read of same address
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h30, 8'h5A, g);
    step(1, 0, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, g);
    idle(3);
    chk("wr1_rd0_0x30", 32'(seen_rd0), 32'h0000_005A);

    // Randomized traffic, requests held until accepted
    for (int x = 0; x < 2; x++) begin
      p_v[x] = 1'b0; p_l[x] = 1'b0; p_w[x] = 1'b0; p_a[x] = '0; p_d[x] = '0;
    end
    for (int i = 0; i < 1500; i++) begin
      for (int x = 0; x < 2; x++) begin
        if (!p_v[x] && ($urandom_range(0, 1) == 1)) begin
          p_v[x] = 1'b1;
          p_l[x] = ($urandom_range(0, 3) == 0);
          p_w[x] = 1'($urandom_range(0, 1));
          p_a[x] = 8'($urandom_range(0, 15));
          p_d[x] = 8'($urandom);
        end
      end
      step(p_v[0], p_l[0], p_w[0], p_a[0], p_d[0],
           p_v[1], p_l[1], p_w[1], p_a[1], p_d[1], g);
      if (g >= 0) p_v[g] = 1'b0;
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
